// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES constants, S-box tables and SubBytes FSM state type
// Purpose: shared AES definitions for the SubBytes engine and the key-expansion path.
// Ports: none (package).
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_BYTES   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_state_t;

  // Entry 0 sits in the most significant byte of each table.
  localparam logic [2047:0] SBOX_FWD_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] SBOX_INV_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // Byte b lives at bit offset (255-b)*8, i.e. {~b, 3'b000}.
  function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
    logic [10:0] idx;
    idx = {~b, 3'b000};
    return SBOX_FWD_TBL[idx +: 8];
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] b);
    logic [10:0] idx;
    idx = {~b, 3'b000};
    return SBOX_INV_TBL[idx +: 8];
  endfunction

endpackage

// File: rtl/sub_bytes_iter_if.sv
// rtl/sub_bytes_iter_if.sv - handshake bundle for the iterative SubBytes engine
// Purpose: groups the input/output valid-ready handshakes, mode and state buses.
// Ports (slave view): in_valid, mode, in_state, out_ready in;
//                     in_ready, out_valid, out_state, busy out.
interface sub_bytes_iter_if;
  import aes_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic                   mode;
  logic [AES_STATE_W-1:0] in_state;
  logic                   out_valid;
  logic                   out_ready;
  logic [AES_STATE_W-1:0] out_state;
  logic                   busy;

  modport slave (
    input  in_valid, mode, in_state, out_ready,
    output in_ready, out_valid, out_state, busy
  );

  modport master (
    output in_valid, mode, in_state, out_ready,
    input  in_ready, out_valid, out_state, busy
  );

endinterface

// File: rtl/sbox_lane.sv
// rtl/sbox_lane.sv - one combinational AES S-box lane (forward, optionally inverse)
// Purpose: substitutes a single byte; no internal registers.
// Ports: din (8) byte in, inv select inverse S-box, dout (8) byte out.
module sbox_lane #(
  parameter int INV_EN = 1
) (
  input  logic [7:0] din,
  input  logic       inv,
  output logic [7:0] dout
);
  import aes_pkg::*;

  generate
    if (INV_EN != 0) begin : g_inv
      assign dout = inv ? sbox_inv(din) : sbox_fwd(din);
    end else begin : g_fwd
      // Forward-only build: the select has nothing to steer.
      logic unused_inv;
      assign unused_inv = inv;
      assign dout       = sbox_fwd(din);
    end
  endgenerate

endmodule

// File: rtl/sub_bytes_iter.sv
// rtl/sub_bytes_iter.sv - iterative AES SubBytes/InvSubBytes over a 128-bit state
// Purpose: substitutes LANES bytes per clock, 16/LANES clocks per state, with
//          per-transaction forward/inverse mode and valid/ready on both sides.
// Ports: clk, rst (async active-high); bus (sub_bytes_iter_if.slave) carrying
//        in_valid/in_ready/mode/in_state, out_valid/out_ready/out_state, busy.
module sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int INV_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  sub_bytes_iter_if.slave bus
);

  localparam int N     = AES_BYTES / LANES;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int GRP_W = 8 * LANES;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  fsm_state_t state_q, state_d;

  // Working state viewed as N groups of LANES bytes; group 0 (bytes
  // 0..LANES-1) occupies the most significant bits.
  logic [N-1:0][GRP_W-1:0] work_q, work_d;
  logic [AES_STATE_W-1:0]  out_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        grp_idx;
  logic                    mode_q;
  logic [GRP_W-1:0]        grp_in, grp_out;
  logic                    accept;
  logic                    last;

  assign bus.in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == RUN);
  assign bus.out_state = out_q;

  assign accept  = bus.in_valid && bus.in_ready;
  assign last    = (cnt_q == CNT_LAST);
  // Counter value c addresses packed group index N-1-c.
  assign grp_idx = CNT_LAST - cnt_q;
  assign grp_in  = work_q[grp_idx];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sbox_lane #(.INV_EN(INV_EN)) u_lane (
      .din  (grp_in [GRP_W-1-8*l -: 8]),
      .inv  (mode_q),
      .dout (grp_out[GRP_W-1-8*l -: 8])
    );
  end

  always_comb begin
    work_d          = work_q;
    work_d[grp_idx] = grp_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      // Draining with a new request waiting skips IDLE entirely.
      DONE:    if (bus.out_ready) state_d = bus.in_valid ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // accept can only happen in IDLE or DONE, so it never collides with RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_q <= '0;
      out_q  <= '0;
      cnt_q  <= '0;
      mode_q <= 1'b0;
    end else if (accept) begin
      work_q <= bus.in_state;
      mode_q <= (INV_EN != 0) ? bus.mode : 1'b0;
      cnt_q  <= '0;
    end else if (state_q == RUN) begin
      work_q <= work_d;
      cnt_q  <= last ? '0 : cnt_q + 1'b1;
      // Result is captured once so out_state holds steady outside DONE.
      if (last) out_q <= work_d;
    end
  end

endmodule
